// File: rtl/stopwatch_pkg.sv
`default_nettype none
// stopwatch_pkg: BCD time type, FSM state type and BCD arithmetic helpers for the lap stopwatch.
// Rev 1.0
package stopwatch_pkg;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
        logic [3:0] tenth;
    } bcd_time_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } sw_state_t;

    localparam bcd_time_t BCD_ZERO = '{tens: 4'd0, ones: 4'd0, tenth: 4'd0};

    // Wraps MAX_TENS9.9 to 00.0; callers detect the wrap themselves.
    function automatic bcd_time_t bcd_inc(input bcd_time_t t, input logic [3:0] max_tens);
        bcd_time_t r;
        r = t;
        if (t.tenth != 4'd9) begin
            r.tenth = t.tenth + 4'd1;
        end else begin
            r.tenth = 4'd0;
            if (t.ones != 4'd9) begin
                r.ones = t.ones + 4'd1;
            end else begin
                r.ones = 4'd0;
                r.tens = (t.tens >= max_tens) ? 4'd0 : t.tens + 4'd1;
            end
        end
        return r;
    endfunction

    function automatic bcd_time_t bcd_dec(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t.tenth != 4'd0) begin
            r.tenth = t.tenth - 4'd1;
        end else begin
            r.tenth = 4'd9;
            if (t.ones != 4'd0) begin
                r.ones = t.ones - 4'd1;
            end else begin
                r.ones = 4'd9;
                r.tens = t.tens - 4'd1;
            end
        end
        return r;
    endfunction

    function automatic bcd_time_t bcd_clamp(input bcd_time_t t, input logic [3:0] max_tens);
        bcd_time_t r;
        r.tens  = (t.tens  > max_tens) ? max_tens : t.tens;
        r.ones  = (t.ones  > 4'd9)     ? 4'd9     : t.ones;
        r.tenth = (t.tenth > 4'd9)     ? 4'd9     : t.tenth;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stopwatch_lap_mem.sv
`default_nettype none
// stopwatch_lap_mem: lap time register file, one write port and one registered read port.
// Rev 1.0
module stopwatch_lap_mem
    import stopwatch_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [11:0]   wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [11:0]   rdata_o
);

    bcd_time_t mem_q [DEPTH];
    bcd_time_t rdata_q;

    // Storage is deliberately left out of reset; lap_count qualifies what is valid.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= bcd_time_t'(wdata_i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= BCD_ZERO;
        end else begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/stopwatch_lap_core.sv
`default_nettype none
// stopwatch_lap_core: BCD tenths stopwatch / countdown timer with a LAP_DEPTH-entry lap buffer.
// Rev 1.0
module stopwatch_lap_core
    import stopwatch_pkg::*;
#(
    parameter int CLKS_PER_TENTH = 5_000_000,
    parameter int LAP_DEPTH      = 8,
    parameter int MAX_TENS       = 5,
    localparam int AW            = $clog2(LAP_DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_stop,
    input  logic          lap_rst,
    input  logic          mode_down,
    input  logic [11:0]   preset,
    input  logic [AW-1:0] rd_idx,
    output logic [11:0]   cur_time,
    output logic          running,
    output logic          done,
    output logic          overflow,
    output logic [AW:0]   lap_count,
    output logic          lap_full,
    output logic [11:0]   rd_time
);

    localparam int             PW         = (CLKS_PER_TENTH > 1) ? $clog2(CLKS_PER_TENTH) : 1;
    localparam logic [PW-1:0]  PRE_LAST   = PW'(CLKS_PER_TENTH - 1);
    localparam logic [3:0]     MAXT       = 4'(MAX_TENS);
    localparam bcd_time_t      TOP_TIME   = '{tens: MAXT, ones: 4'd9, tenth: 4'd9};
    localparam bcd_time_t      ONE_TENTH  = '{tens: 4'd0, ones: 4'd0, tenth: 4'd1};
    localparam logic [AW:0]    DEPTH_CNT  = (AW+1)'(LAP_DEPTH);

    sw_state_t     state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    bcd_time_t     cur_q, cur_d;
    logic          ovf_q, ovf_d;
    logic [AW:0]   lap_cnt_q, lap_cnt_d;
    logic          down_q, down_d;
    logic          tick;
    logic          lap_we;
    logic          full;
    bcd_time_t     preset_c;

    assign tick     = (state_q == RUN) && (pre_q == PRE_LAST);
    assign full     = (lap_cnt_q == DEPTH_CNT);
    assign preset_c = bcd_clamp(bcd_time_t'(preset), MAXT);

    always_comb begin
        state_d   = state_q;
        pre_d     = pre_q;
        cur_d     = cur_q;
        ovf_d     = ovf_q;
        lap_cnt_d = lap_cnt_q;
        down_d    = down_q;
        lap_we    = 1'b0;

        if (state_q == RUN) begin
            pre_d = tick ? '0 : pre_q + 1'b1;
            if (tick) begin
                if (down_q) begin
                    cur_d = bcd_dec(cur_q);
                end else begin
                    cur_d = bcd_inc(cur_q, MAXT);
                    if (cur_q == TOP_TIME) begin
                        ovf_d = 1'b1;
                    end
                end
            end
        end

        case (state_q)
            IDLE: begin
                if (start_stop) begin
                    if (!mode_down) begin
                        state_d = RUN;
                        down_d  = 1'b0;
                    end else if (preset_c != BCD_ZERO) begin
                        state_d = RUN;
                        down_d  = 1'b1;
                        cur_d   = preset_c;
                    end
                end
            end
            RUN: begin
                // Expiry outranks a pause request arriving on the same edge.
                if (tick && down_q && (cur_q == ONE_TENTH)) begin
                    state_d = DONE;
                end else if (start_stop) begin
                    state_d = PAUSE;
                end
                if (lap_rst && !start_stop && !full) begin
                    lap_we    = 1'b1;
                    lap_cnt_d = lap_cnt_q + 1'b1;
                end
            end
            PAUSE, DONE: begin
                if (start_stop) begin
                    if (state_q == PAUSE) begin
                        state_d = RUN;
                    end
                end else if (lap_rst) begin
                    state_d   = IDLE;
                    cur_d     = BCD_ZERO;
                    ovf_d     = 1'b0;
                    lap_cnt_d = '0;
                    pre_d     = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pre_q     <= '0;
            cur_q     <= BCD_ZERO;
            ovf_q     <= 1'b0;
            lap_cnt_q <= '0;
            down_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            cur_q     <= cur_d;
            ovf_q     <= ovf_d;
            lap_cnt_q <= lap_cnt_d;
            down_q    <= down_d;
        end
    end

    stopwatch_lap_mem #(
        .DEPTH (LAP_DEPTH),
        .AW    (AW)
    ) u_lap_mem (
        .clk     (clk),
        .rst     (rst),
        .we_i    (lap_we),
        .waddr_i (lap_cnt_q[AW-1:0]),
        .wdata_i (cur_q),
        .raddr_i (rd_idx),
        .rdata_o (rd_time)
    );

    assign cur_time  = cur_q;
    assign running   = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign overflow  = ovf_q;
    assign lap_count = lap_cnt_q;
    assign lap_full  = full;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_lap_core.sv
`default_nettype none
// tb_stopwatch_lap_core: directed and random checks of stopwatch_lap_core against an integer-time model.
// Rev 1.0
`timescale 1ns/1ps
module tb_stopwatch_lap_core;

    localparam int CPT   = 4;
    localparam int DEPTH = 8;
    localparam int MAXT  = 5;
    localparam int AW    = 3;
    localparam int TOP   = MAXT * 100 + 99;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_stop;
    logic          lap_rst;
    logic          mode_down;
    logic [11:0]   preset;
    logic [AW-1:0] rd_idx;
    logic [11:0]   cur_time;
    logic          running;
    logic          done;
    logic          overflow;
    logic [AW:0]   lap_count;
    logic          lap_full;
    logic [11:0]   rd_time;

    stopwatch_lap_core #(
        .CLKS_PER_TENTH (CPT),
        .LAP_DEPTH      (DEPTH),
        .MAX_TENS       (MAXT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_stop (start_stop),
        .lap_rst    (lap_rst),
        .mode_down  (mode_down),
        .preset     (preset),
        .rd_idx     (rd_idx),
        .cur_time   (cur_time),
        .running    (running),
        .done       (done),
        .overflow   (overflow),
        .lap_count  (lap_count),
        .lap_full   (lap_full),
        .rd_time    (rd_time)
    );

    always #5 clk = ~clk;

    // Model: time is a plain integer count of tenths; states 0 idle, 1 run, 2 pause, 3 done.
    int m_state, m_t, m_pre, m_ovf, m_cnt, m_down;
    int m_buf [DEPTH];
    int exp_rd;
    bit exp_rd_valid;
    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int t);
        logic [11:0] r;
        r[11:8] = 4'(t / 100);
        r[7:4]  = 4'((t / 10) % 10);
        r[3:0]  = 4'(t % 10);
        return r;
    endfunction

    function automatic int clamp_val(input logic [11:0] p);
        int tn, on, tt;
        tn = int'(p[11:8]);
        on = int'(p[7:4]);
        tt = int'(p[3:0]);
        if (tn > MAXT) tn = MAXT;
        if (on > 9) on = 9;
        if (tt > 9) tt = 9;
        return tn * 100 + on * 10 + tt;
    endfunction

    task automatic model_reset();
        m_state = 0; m_t = 0; m_pre = 0; m_ovf = 0; m_cnt = 0; m_down = 0;
        exp_rd_valid = 1'b0;
    endtask

    task automatic model_clear(inout int ns, inout int nt);
        ns = 0; nt = 0; m_ovf = 0; m_cnt = 0; m_pre = 0;
    endtask

    task automatic model_edge();
        int ns, nt;
        bit tick;
        tick = (m_state == 1) && (m_pre == CPT - 1);
        exp_rd_valid = int'(rd_idx) < m_cnt;
        exp_rd = m_buf[rd_idx];
        ns = m_state;
        nt = m_t;
        if (m_state == 1) begin
            m_pre = tick ? 0 : m_pre + 1;
            if (tick) begin
                if (m_down != 0)   nt = m_t - 1;
                else if (m_t == TOP) begin nt = 0; m_ovf = 1; end
                else               nt = m_t + 1;
            end
        end
        case (m_state)
            0: if (start_stop) begin
                if (!mode_down) begin ns = 1; m_down = 0; end
                else if (clamp_val(preset) != 0) begin ns = 1; m_down = 1; nt = clamp_val(preset); end
            end
            1: begin
                if (tick && m_down != 0 && nt == 0) ns = 3;
                else if (start_stop) ns = 2;
                if (lap_rst && !start_stop && m_cnt < DEPTH) begin
                    m_buf[m_cnt] = m_t;
                    m_cnt++;
                end
            end
            2: if (start_stop) ns = 1;
               else if (lap_rst) model_clear(ns, nt);
            default: if (!start_stop && lap_rst) model_clear(ns, nt);
        endcase
        m_state = ns;
        m_t = nt;
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".cur"},     32'(cur_time),  32'(to_bcd(m_t)));
        check({tag, ".running"}, 32'(running),   32'(m_state == 1));
        check({tag, ".done"},    32'(done),      32'(m_state == 3));
        check({tag, ".ovf"},     32'(overflow),  32'(m_ovf));
        check({tag, ".cnt"},     32'(lap_count), 32'(m_cnt));
        check({tag, ".full"},    32'(lap_full),  32'(m_cnt == DEPTH));
        if (exp_rd_valid) check({tag, ".rd"}, 32'(rd_time), 32'(to_bcd(exp_rd)));
    endtask

    task automatic step(input logic ss, input logic lr, input string tag);
        start_stop = ss;
        lap_rst    = lr;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        start_stop = 1'b0;
        lap_rst    = 1'b0;
        compare_all(tag);
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, tag);
    endtask

    task automatic run_to(input int t, input string tag);
        int g;
        g = 0;
        while (m_t != t && g < 5000) begin
            step(1'b0, 1'b0, tag);
            g++;
        end
        check({tag, ".bound"}, 32'(g < 5000), 32'd1);
    endtask

    initial begin
        rst = 1'b1; start_stop = 1'b0; lap_rst = 1'b0; mode_down = 1'b0;
        preset = 12'h000; rd_idx = '0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all("reset");
        check("reset.rd", 32'(rd_time), 32'h0);
        rst = 1'b0;

        // Up count and pause hold
        step(1'b1, 1'b0, "t1.start");
        run(25 * CPT, "t1.run");
        check("t1.time", 32'(cur_time), 32'h025);
        check("t1.running", 32'(running), 32'd1);
        step(1'b1, 1'b0, "t1.pause");
        run(10 * CPT, "t1.hold");
        check("t1.held", 32'(cur_time), 32'h025);
        step(1'b0, 1'b1, "t1.clear");

        // Wrap past 59.9
        step(1'b1, 1'b0, "t2.start");
        run(600 * CPT, "t2.run");
        check("t2.time", 32'(cur_time), 32'h000);
        check("t2.ovf", 32'(overflow), 32'd1);
        check("t2.running", 32'(running), 32'd1);
        step(1'b1, 1'b0, "t2.pause");
        step(1'b0, 1'b1, "t2.clear");
        check("t2.ovf_clr", 32'(overflow), 32'd0);

        // Laps and readback
        step(1'b1, 1'b0, "t3.start");
        run_to(12, "t3.to12");
        step(1'b0, 1'b1, "t3.lap1");
        run_to(34, "t3.to34");
        step(1'b0, 1'b1, "t3.lap2");
        check("t3.cnt2", 32'(lap_count), 32'd2);
        rd_idx = 3'd1;
        step(1'b0, 1'b0, "t3.rd1");
        check("t3.rd1val", 32'(rd_time), 32'h034);
        for (int i = 0; i < 7; i++) begin
            run(3, "t3.gap");
            step(1'b0, 1'b1, "t3.lapn");
        end
        check("t3.cnt8", 32'(lap_count), 32'd8);
        check("t3.full", 32'(lap_full), 32'd1);
        rd_idx = 3'd7;
        step(1'b0, 1'b0, "t3.rd7");
        check("t3.rd7val", 32'(rd_time), 32'(to_bcd(m_buf[7])));
        step(1'b1, 1'b0, "t3.pause");
        step(1'b0, 1'b1, "t3.clear");
        rd_idx = '0;

        // Countdown expiry
        mode_down = 1'b1; preset = 12'h003;
        step(1'b1, 1'b0, "t4.start");
        check("t4.load", 32'(cur_time), 32'h003);
        run(3 * CPT, "t4.run");
        check("t4.zero", 32'(cur_time), 32'h000);
        check("t4.done", 32'(done), 32'd1);
        check("t4.stopped", 32'(running), 32'd0);
        step(1'b1, 1'b0, "t4.ss_ignored");
        step(1'b0, 1'b1, "t4.clear");
        check("t4.done_clr", 32'(done), 32'd0);

        // Edge cases
        mode_down = 1'b0;
        step(1'b1, 1'b0, "t5.start");
        run_to(10, "t5.to10");
        step(1'b1, 1'b1, "t5.both");
        check("t5.paused", 32'(running), 32'd0);
        check("t5.nolap", 32'(lap_count), 32'd0);
        step(1'b0, 1'b1, "t5.clear");
        mode_down = 1'b1; preset = 12'h000;
        step(1'b1, 1'b0, "t5.zero_start");
        check("t5.zero_idle", 32'(running), 32'd0);
        preset = 12'h7FA;
        step(1'b1, 1'b0, "t5.clamp");
        check("t5.clamped", 32'(cur_time), 32'h599);
        step(1'b1, 1'b0, "t5.pause");
        step(1'b0, 1'b1, "t5.clear");
        mode_down = 1'b0;

        // Asynchronous reset mid-run
        step(1'b1, 1'b0, "t6.start");
        for (int i = 0; i < 3; i++) begin
            run(5, "t6.gap");
            step(1'b0, 1'b1, "t6.lap");
        end
        run_to(47, "t6.to47");
        #2 rst = 1'b1;
        #1;
        model_reset();
        compare_all("t6.async");
        check("t6.rd", 32'(rd_time), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 1'b0, "t6.restart");
        run(3 * CPT, "t6.run");
        check("t6.time", 32'(cur_time), 32'h003);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            mode_down = 1'($urandom_range(0, 1));
            preset    = ($urandom_range(0, 2) == 0) ? 12'h002 : 12'($urandom);
            rd_idx    = AW'($urandom);
            step(1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 15) == 0), "rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
